// File: rtl/alu_bist_seq.sv
// alu_bist_seq: built-in self-test sequencer for a 16-bit ALU.
// A 33-bit LFSR supplies {a, b, cin}; each of the 8 opcodes gets VECS_PER_OP
// vectors. Operands are held SETTLE_CYCLES cycles, then the ALU result and
// flags are folded into an 18-bit MISR signature.
// Optional feature: define ALU_BIST_FLAGCHK_EN to check the zero/neg flags
// against the result during capture (sticky err plus saturating err_cnt).
// Without the macro, err and err_cnt are tied to 0.
//
// Handshake: start is a level that is only honoured in IDLE or DONE. busy is
// high for the whole run. done stays high, and every result output holds its
// value, until the next start or rst.
// dbg_state mirrors the FSM register (0 = IDLE, 1 = SETTLE, 2 = CAPTURE, 3 = DONE).
module alu_bist_seq #(
    parameter int unsigned VECS_PER_OP   = 10,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [32:0] SEED          = 33'h0DEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        cin,
    output logic [2:0]  opc,
    input  logic [15:0] w,
    input  logic        zero,
    input  logic        neg,
    output logic        busy,
    output logic        done,
    output logic [17:0] signature,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [32:0] SEED_EFF    = (SEED == 33'd0) ? 33'd1 : SEED;
    localparam logic [7:0]  LAST_VEC    = 8'(VECS_PER_OP - 1);
    localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [32:0] r_lfsr;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_cin;
    logic [2:0]  r_opc;
    logic [7:0]  r_vec_cnt;
    logic [3:0]  r_settle_cnt;
    logic        r_busy;
    logic        r_done;
    logic [17:0] r_sig;

    logic        w_load;
    logic        w_advance;
    logic        w_last_vec;
    logic        w_last_settle;
    logic [32:0] w_lfsr_step;
    logic [32:0] w_lfsr_nxt;
    logic [17:0] w_sig_nxt;

    assign w_last_vec    = (r_vec_cnt == LAST_VEC);
    assign w_last_settle = (r_settle_cnt == LAST_SETTLE);
    assign w_lfsr_step   = {r_lfsr[31:0], r_lfsr[32] ^ r_lfsr[19]};
    assign w_lfsr_nxt    = w_load ? SEED_EFF : (w_advance ? w_lfsr_step : r_lfsr);
    assign w_sig_nxt     = {r_sig[16:0], r_sig[17] ^ r_sig[10]} ^ {w, zero, neg};

    // Next-state decode: start only counts in IDLE/DONE; the LFSR steps as CAPTURE is left.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_load      = 1'b1;
                end
            end
            S_SETTLE: begin
                if (w_last_settle) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_advance = 1'b1;
                if (w_last_vec && (r_opc == 3'd7)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/done, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CAPTURE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // LFSR and operand registers; operands follow the LFSR whenever it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED_EFF;
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_cin  <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (w_load || w_advance) begin
                r_a   <= w_lfsr_nxt[32:17];
                r_b   <= w_lfsr_nxt[16:1];
                r_cin <= w_lfsr_nxt[0];
            end
        end
    end

    // Settle timer, vector/opcode counters and MISR signature.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opc        <= 3'd0;
            r_vec_cnt    <= 8'd0;
            r_settle_cnt <= 4'd0;
            r_sig        <= 18'd0;
        end else if (w_load) begin
            r_opc        <= 3'd0;
            r_vec_cnt    <= 8'd0;
            r_settle_cnt <= 4'd0;
            r_sig        <= 18'd0;
        end else if (r_state == S_SETTLE) begin
            r_settle_cnt <= w_last_settle ? 4'd0 : (r_settle_cnt + 4'd1);
        end else if (r_state == S_CAPTURE) begin
            r_sig <= w_sig_nxt;
            if (!w_last_vec) begin
                r_vec_cnt <= r_vec_cnt + 8'd1;
            end else if (r_opc != 3'd7) begin
                r_vec_cnt <= 8'd0;
                r_opc     <= r_opc + 3'd1;
            end
        end
    end

`ifdef ALU_BIST_FLAGCHK_EN
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_flag_bad;

    assign w_flag_bad = (zero != (w == 16'd0)) || (neg != w[15]);

    // Flag checker: sticky error and a saturating count of inconsistent captures.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if ((r_state == S_CAPTURE) && w_flag_bad) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    assign err     = 1'b0;
    assign err_cnt = 8'd0;
`endif

    assign a         = r_a;
    assign b         = r_b;
    assign cin       = r_cin;
    assign opc       = r_opc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_sig;
    assign dbg_state = r_state;

endmodule
